// File: rtl/pe_job_sequencer.sv
// pe_job_sequencer: runs one PE job at a time. It loads the filter and IF
// FIFOs from a shared input stream, pulses pe_start, then drains results.
// Ports:
//   cfg_*         job descriptor (filter/IF/result word counts)
//   in_*          shared input stream (valid/ready)
//   filt_*, if_*  filter and IF FIFO write side
//   pe_start      one-cycle PE start pulse
//   out_*         output FIFO read side (dout valid the cycle after ren)
//   m_*           registered result stream (valid/ready)
//   busy, done    job status; done pulses for one cycle at job end
module pe_job_sequencer #(
  parameter int IF_W   = 10,
  parameter int FILT_W = 8,
  parameter int OUT_W  = 19,
  parameter int DIN_W  = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_filt_words,
  input  logic [CNT_W-1:0]  cfg_if_words,
  input  logic [CNT_W-1:0]  cfg_out_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_W-1:0]  in_data,
  output logic              filt_wen,
  output logic [FILT_W-1:0] filt_din,
  input  logic              filt_full,
  output logic              if_wen,
  output logic [IF_W-1:0]   if_din,
  input  logic              if_full,
  output logic              pe_start,
  output logic              out_ren,
  input  logic [OUT_W-1:0]  out_dout,
  input  logic              out_empty,
  output logic              m_valid,
  output logic [OUT_W-1:0]  m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FILT,
    S_LOAD_IF,
    S_START,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [CNT_W-1:0] if_cnt_q, if_cnt_d;
  logic [CNT_W-1:0] out_tot_q, out_tot_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             pend_q, pend_d;
  logic             mval_q, mval_d;
  logic [OUT_W-1:0] mdata_q, mdata_d;

  assign filt_din = in_data[FILT_W-1:0];
  assign if_din   = in_data[IF_W-1:0];
  assign m_valid  = mval_q;
  assign m_data   = mdata_q;
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      filt_cnt_q <= '0;
      if_cnt_q   <= '0;
      out_tot_q  <= '0;
      rd_cnt_q   <= '0;
      rem_q      <= '0;
      pend_q     <= 1'b0;
      mval_q     <= 1'b0;
      mdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      filt_cnt_q <= filt_cnt_d;
      if_cnt_q   <= if_cnt_d;
      out_tot_q  <= out_tot_d;
      rd_cnt_q   <= rd_cnt_d;
      rem_q      <= rem_d;
      pend_q     <= pend_d;
      mval_q     <= mval_d;
      mdata_q    <= mdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    filt_cnt_d = filt_cnt_q;
    if_cnt_d   = if_cnt_q;
    out_tot_d  = out_tot_q;
    rd_cnt_d   = rd_cnt_q;
    rem_d      = rem_q;
    pend_d     = pend_q;
    mval_d     = mval_q;
    mdata_d    = mdata_q;
    cfg_ready  = 1'b0;
    in_ready   = 1'b0;
    filt_wen   = 1'b0;
    if_wen     = 1'b0;
    pe_start   = 1'b0;
    out_ren    = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          filt_cnt_d = cfg_filt_words;
          if_cnt_d   = cfg_if_words;
          out_tot_d  = cfg_out_words;
          rem_d      = cfg_out_words;
          rd_cnt_d   = '0;
          pend_d     = 1'b0;
          if (cfg_filt_words != '0)
            state_d = S_LOAD_FILT;
          else if (cfg_if_words != '0)
            state_d = S_LOAD_IF;
          else
            state_d = S_START;
        end
      end
      S_LOAD_FILT: begin
        in_ready = ~filt_full;
        filt_wen = in_valid & ~filt_full;
        if (filt_wen) begin
          filt_cnt_d = filt_cnt_q - ONE;
          if (filt_cnt_q == ONE)
            state_d = (if_cnt_q != '0) ? S_LOAD_IF : S_START;
        end
      end
      S_LOAD_IF: begin
        in_ready = ~if_full;
        if_wen   = in_valid & ~if_full;
        if (if_wen) begin
          if_cnt_d = if_cnt_q - ONE;
          if (if_cnt_q == ONE)
            state_d = S_START;
        end
      end
      S_START: begin
        pe_start = 1'b1;
        state_d  = (out_tot_q != '0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        // Single read in flight; the next read waits until the
        // held word has been accepted downstream.
        out_ren = ~out_empty & ~pend_q & ~mval_q
                & (rd_cnt_q < out_tot_q);
        if (out_ren) begin
          pend_d   = 1'b1;
          rd_cnt_d = rd_cnt_q + ONE;
        end
        if (pend_q) begin
          pend_d  = 1'b0;
          mval_d  = 1'b1;
          mdata_d = out_dout;
        end
        if (mval_q && m_ready) begin
          mval_d = 1'b0;
          rem_d  = rem_q - ONE;
          if (rem_q == ONE)
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_job_sequencer.sv
// tb_pe_job_sequencer: randomized scoreboard bench for pe_job_sequencer.
// Environment models the FIFOs and stream partners with queues.
module tb_pe_job_sequencer;

  localparam int IF_W   = 10;
  localparam int FILT_W = 8;
  localparam int OUT_W  = 19;
  localparam int DIN_W  = 10;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rstn;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_filt_words;
  logic [CNT_W-1:0]  cfg_if_words;
  logic [CNT_W-1:0]  cfg_out_words;
  logic              in_valid;
  logic              in_ready;
  logic [DIN_W-1:0]  in_data;
  logic              filt_wen;
  logic [FILT_W-1:0] filt_din;
  logic              filt_full;
  logic              if_wen;
  logic [IF_W-1:0]   if_din;
  logic              if_full;
  logic              pe_start;
  logic              out_ren;
  logic [OUT_W-1:0]  out_dout;
  logic              out_empty;
  logic              m_valid;
  logic [OUT_W-1:0]  m_data;
  logic              m_ready;
  logic              busy;
  logic              done;

  pe_job_sequencer #(
    .IF_W(IF_W), .FILT_W(FILT_W), .OUT_W(OUT_W),
    .DIN_W(DIN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_filt_words(cfg_filt_words),
    .cfg_if_words(cfg_if_words),
    .cfg_out_words(cfg_out_words),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .filt_wen(filt_wen), .filt_din(filt_din),
    .filt_full(filt_full),
    .if_wen(if_wen), .if_din(if_din), .if_full(if_full),
    .pe_start(pe_start),
    .out_ren(out_ren), .out_dout(out_dout),
    .out_empty(out_empty),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DIN_W-1:0]  instream[$];
  logic [FILT_W-1:0] exp_filt[$];
  logic [IF_W-1:0]   exp_if[$];
  logic [OUT_W-1:0]  ofifo[$];
  logic [OUT_W-1:0]  exp_out[$];

  int p_valid = 100;
  int p_full  = 0;
  int p_empty = 0;
  int p_ready = 100;
  bit tog_mode = 0;
  bit tog = 0;
  int ffull_hold = 0;
  int mr_hold = 0;

  bit s_in_hs, s_ren, s_mvalid;
  bit prev_stall;
  logic [OUT_W-1:0] prev_data;
  int cyc = 0, hs_cyc = 0, ps_cyc = 0, done_cyc = 0;
  int done_cnt = 0, ps_cnt = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Environment: FIFO and stream partners, updated just after each edge.
  always @(posedge clk) begin
    logic [DIN_W-1:0] tmp;
    #1;
    if (rstn) begin
      if (s_in_hs && instream.size() > 0)
        tmp = instream.pop_front();
      if (s_ren && ofifo.size() > 0)
        out_dout = ofifo.pop_front();
      if (s_mvalid && mr_hold > 0) mr_hold--;
      if (ffull_hold > 0) ffull_hold--;
    end
    tog = ~tog;
    in_valid = (instream.size() > 0)
             && ($urandom_range(99) < p_valid);
    in_data = (instream.size() > 0) ? instream[0]
            : DIN_W'($urandom);
    filt_full = (ffull_hold > 0)
              || ($urandom_range(99) < p_full);
    if_full = ($urandom_range(99) < p_full);
    out_empty = (ofifo.size() == 0)
              || (tog_mode ? tog
                  : ($urandom_range(99) < p_empty));
    m_ready = (mr_hold == 0)
            && ($urandom_range(99) < p_ready);
  end

  // Monitor: samples mid-cycle, checks against the expected queues.
  always @(negedge clk) begin
    logic [FILT_W-1:0] e8;
    logic [IF_W-1:0]   e10;
    logic [OUT_W-1:0]  eo;
    if (!rstn) begin
      s_in_hs = 0; s_ren = 0; s_mvalid = 0;
      prev_stall = 0; ps_cnt = 0;
    end else begin
      cyc++;
      chk(busy == !cfg_ready, "busy_vs_ready",
          busy, !cfg_ready);
      if (cfg_valid && cfg_ready) hs_cyc = cyc;
      if (in_valid && in_ready)
        chk(filt_wen | if_wen, "hs_no_write",
            {filt_wen, if_wen}, 1);
      if (filt_full && if_full)
        chk(!in_ready, "ready_when_full", in_ready, 0);
      if (filt_wen) begin
        chk(!filt_full && in_valid && in_ready,
            "filt_wen_cond",
            {filt_full, in_valid, in_ready}, 3'b011);
        chk(exp_filt.size() != 0, "filt_extra_write",
            filt_din, 0);
        if (exp_filt.size() != 0) begin
          e8 = exp_filt.pop_front();
          chk(filt_din == e8, "filt_din", filt_din, e8);
        end
      end
      if (if_wen) begin
        chk(!if_full && in_valid && in_ready,
            "if_wen_cond",
            {if_full, in_valid, in_ready}, 3'b011);
        chk(exp_if.size() != 0, "if_extra_write",
            if_din, 0);
        if (exp_if.size() != 0) begin
          e10 = exp_if.pop_front();
          chk(if_din == e10, "if_din", if_din, e10);
        end
      end
      if (pe_start) begin
        ps_cyc = cyc;
        ps_cnt++;
        chk(exp_filt.size() + exp_if.size() == 0,
            "start_before_load_end",
            exp_filt.size() + exp_if.size(), 0);
      end
      if (out_ren)
        chk(!out_empty && !m_valid, "ren_cond",
            {out_empty, m_valid}, 0);
      if (prev_stall)
        chk(m_valid && m_data == prev_data,
            "m_hold_stable", m_data, prev_data);
      if (m_valid && m_ready) begin
        chk(exp_out.size() != 0, "m_extra_word",
            m_data, 0);
        if (exp_out.size() != 0) begin
          eo = exp_out.pop_front();
          chk(m_data == eo, "m_data", m_data, eo);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
        chk(exp_out.size() == 0, "done_words_left",
            exp_out.size(), 0);
        chk(ps_cnt == 1, "pe_start_count", ps_cnt, 1);
        ps_cnt = 0;
      end
      s_in_hs = in_valid && in_ready;
      s_ren = out_ren;
      s_mvalid = m_valid;
    end
  end

  task automatic chk_reset_outs();
    chk(cfg_ready == 1, "rst_cfg_ready", cfg_ready, 1);
    chk(in_ready == 0, "rst_in_ready", in_ready, 0);
    chk(filt_wen == 0, "rst_filt_wen", filt_wen, 0);
    chk(if_wen == 0, "rst_if_wen", if_wen, 0);
    chk(pe_start == 0, "rst_pe_start", pe_start, 0);
    chk(out_ren == 0, "rst_out_ren", out_ren, 0);
    chk(m_valid == 0, "rst_m_valid", m_valid, 0);
    chk(m_data == 0, "rst_m_data", m_data, 0);
    chk(busy == 0, "rst_busy", busy, 0);
    chk(done == 0, "rst_done", done, 0);
  endtask

  task automatic load_job(input int f, input int i,
                          input int o);
    logic [DIN_W-1:0] w;
    logic [OUT_W-1:0] r;
    for (int k = 0; k < f + i; k++) begin
      w = DIN_W'($urandom);
      instream.push_back(w);
      if (k < f) exp_filt.push_back(w[FILT_W-1:0]);
      else exp_if.push_back(w[IF_W-1:0]);
    end
    instream.push_back(DIN_W'($urandom));
    for (int k = 0; k < o; k++) begin
      r = OUT_W'($urandom);
      ofifo.push_back(r);
      exp_out.push_back(r);
    end
  endtask

  task automatic issue_cfg(input int f, input int i,
                           input int o, input int ffh);
    @(posedge clk); #2;
    cfg_filt_words = CNT_W'(f);
    cfg_if_words = CNT_W'(i);
    cfg_out_words = CNT_W'(o);
    cfg_valid = 1;
    @(posedge clk); #2;
    cfg_valid = 0;
    if (ffh > 0) begin
      ffull_hold = ffh;
      filt_full = 1;
    end
  endtask

  task automatic run_job(input int f, input int i,
                         input int o, input int e_ps,
                         input int e_done, input int ffh,
                         input int mrh);
    int d0, n;
    mr_hold = mrh;
    load_job(f, i, o);
    d0 = done_cnt;
    issue_cfg(f, i, o, ffh);
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(done_cnt != d0, "job_timeout", n, 3000);
    if (e_ps >= 0)
      chk(ps_cyc - hs_cyc == e_ps, "start_latency",
          ps_cyc - hs_cyc, e_ps);
    if (e_done >= 0)
      chk(done_cyc - hs_cyc == e_done, "done_latency",
          done_cyc - hs_cyc, e_done);
    chk(instream.size() == 1, "extra_beat_kept",
        instream.size(), 1);
    #3;
    chk(cfg_ready && !busy, "idle_after_done",
        {cfg_ready, busy}, 2'b10);
    instream.delete();
  endtask

  initial begin
    int n;
    bit seen;
    rstn = 1;
    cfg_valid = 0;
    cfg_filt_words = 0;
    cfg_if_words = 0;
    cfg_out_words = 0;
    in_valid = 0;
    in_data = 0;
    filt_full = 0;
    if_full = 0;
    out_dout = 0;
    out_empty = 1;
    m_ready = 0;
    #1 rstn = 0;
    #1 chk_reset_outs();
    repeat (3) @(posedge clk);
    #2 rstn = 1;

    run_job(3, 5, 2, 9, 16, 0, 0);
    run_job(3, 5, 2, 13, 20, 4, 0);
    run_job(3, 5, 2, 9, 21, 0, 5);
    run_job(0, 0, 0, 1, 2, 0, 0);
    tog_mode = 1;
    run_job(2, 2, 4, -1, -1, 0, 0);
    tog_mode = 0;

    load_job(2, 6, 2);
    issue_cfg(2, 6, 2, 0);
    seen = 0;
    n = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = if_wen;
      n++;
    end
    chk(seen, "reach_load_if", n, 100);
    @(negedge clk);
    #2 rstn = 0;
    #1 chk_reset_outs();
    instream.delete();
    exp_filt.delete();
    exp_if.delete();
    ofifo.delete();
    exp_out.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1;
    run_job(2, 3, 3, -1, -1, 0, 0);

    for (int j = 0; j < 40; j++) begin
      p_valid = $urandom_range(100, 40);
      p_full = $urandom_range(40, 0);
      p_empty = $urandom_range(50, 0);
      p_ready = $urandom_range(100, 30);
      run_job($urandom_range(6, 0), $urandom_range(6, 0),
              $urandom_range(6, 0), -1, -1, 0,
              $urandom_range(3, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
